// File: rtl/cache_line_burst_unit.sv
// Cache-line transfer engine: splits one line read/write into word requests on the memory port.
// Optional macro CACHE_BURST_CRIT_WORD_FIRST_EN: reads fetch the addressed word first and wrap.
module cache_line_burst_unit #(
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cmd_val,
   output logic                             cmd_rdy,
   input  logic                             cmd_rw,
   input  logic [ADDR_W-1:0]                cmd_addr,
   input  logic [WORDS_PER_LINE*DATA_W-1:0] cmd_wdata,
   output logic                             mem_req_val,
   input  logic                             mem_req_rdy,
   output logic                             mem_req_type,
   output logic [ADDR_W-1:0]                mem_req_addr,
   output logic [DATA_W-1:0]                mem_req_data,
   input  logic                             mem_resp_val,
   output logic                             mem_resp_rdy,
   input  logic [DATA_W-1:0]                mem_resp_data,
   output logic                             line_val,
   input  logic                             line_rdy,
   output logic [WORDS_PER_LINE*DATA_W-1:0] line_data,
   output logic                             busy
);

   localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned OFF_W = IDX_W + 2;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_LINE);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] XFER = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]                               state_q, state_d;
   logic                                     rw_q, rw_d;
   logic [ADDR_W-1:0]                        base_q, base_d;
   logic [IDX_W-1:0]                         start_q, start_d;
   logic [WORDS_PER_LINE-1:0][DATA_W-1:0]    line_q, line_d;
   logic [CNT_W-1:0]                         issue_q, issue_d;
   logic [CNT_W-1:0]                         resp_q, resp_d;

   logic                                     cmd_rdy_d, busy_d, line_val_d;
   logic                                     req_val_d, req_type_d;
   logic [ADDR_W-1:0]                        req_addr_d;
   logic [DATA_W-1:0]                        req_data_d;

   logic                                     req_fire, resp_fire;
   logic [IDX_W-1:0]                         cmd_start, resp_idx, next_idx;
   logic [ADDR_W-1:0]                        cmd_base;
   logic                                     unused_addr_bits;

   // Writes always stream from word 0; only reads may start mid-line
`ifdef CACHE_BURST_CRIT_WORD_FIRST_EN
   assign cmd_start = cmd_rw ? '0 : cmd_addr[OFF_W-1:2];
`else
   assign cmd_start = '0;
`endif

   assign cmd_base         = {cmd_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign unused_addr_bits = ^cmd_addr[OFF_W-1:0];

   assign req_fire     = mem_req_val && mem_req_rdy;
   // A response may ride along with the request being issued this cycle
   assign mem_resp_rdy = (state_q == XFER) && ((resp_q < issue_q) || req_fire);
   assign resp_fire    = mem_resp_val && mem_resp_rdy;
   assign resp_idx     = start_q + resp_q[IDX_W-1:0];
   assign line_data    = line_q;

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      rw_d       = rw_q;
      base_d     = base_q;
      start_d    = start_q;
      line_d     = line_q;
      issue_d    = issue_q;
      resp_d     = resp_q;
      cmd_rdy_d  = cmd_rdy;
      busy_d     = busy;
      line_val_d = line_val;
      req_val_d  = mem_req_val;
      req_type_d = mem_req_type;
      req_addr_d = mem_req_addr;
      req_data_d = mem_req_data;
      next_idx   = '0;

      case (state_q)
         IDLE: begin
            if (cmd_val) begin
               state_d    = XFER;
               rw_d       = cmd_rw;
               base_d     = cmd_base;
               start_d    = cmd_start;
               line_d     = cmd_wdata;
               issue_d    = '0;
               resp_d     = '0;
               cmd_rdy_d  = 1'b0;
               busy_d     = 1'b1;
               req_val_d  = 1'b1;
               req_type_d = cmd_rw;
               req_addr_d = cmd_base | ADDR_W'({cmd_start, 2'b00});
               req_data_d = cmd_rw ? cmd_wdata[DATA_W-1:0] : '0;
            end
         end

         XFER: begin
            if (req_fire) begin
               issue_d = issue_q + CNT_W'(1);
            end
            next_idx   = start_q + issue_d[IDX_W-1:0];
            req_val_d  = (issue_d < CNT_FULL);
            req_addr_d = req_val_d ? (base_q | ADDR_W'({next_idx, 2'b00})) : '0;
            req_data_d = (req_val_d && rw_q) ? line_q[next_idx] : '0;

            if (resp_fire) begin
               resp_d = resp_q + CNT_W'(1);
               if (!rw_q) begin
                  line_d[resp_idx] = mem_resp_data;
               end
            end

            if (resp_d == CNT_FULL) begin
               state_d    = rw_q ? IDLE : DONE;
               cmd_rdy_d  = rw_q;
               busy_d     = !rw_q;
               line_val_d = !rw_q;
               req_val_d  = 1'b0;
               req_addr_d = '0;
               req_data_d = '0;
            end
         end

         DONE: begin
            if (line_rdy) begin
               state_d    = IDLE;
               line_val_d = 1'b0;
               cmd_rdy_d  = 1'b1;
               busy_d     = 1'b0;
            end
         end

         default: begin
            state_d    = IDLE;
            cmd_rdy_d  = 1'b1;
            busy_d     = 1'b0;
            line_val_d = 1'b0;
            req_val_d  = 1'b0;
            req_addr_d = '0;
            req_data_d = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         base_q       <= '0;
         start_q      <= '0;
         line_q       <= '0;
         issue_q      <= '0;
         resp_q       <= '0;
         cmd_rdy      <= 1'b1;
         busy         <= 1'b0;
         line_val     <= 1'b0;
         mem_req_val  <= 1'b0;
         mem_req_type <= 1'b0;
         mem_req_addr <= '0;
         mem_req_data <= '0;
      end else begin
         state_q      <= state_d;
         rw_q         <= rw_d;
         base_q       <= base_d;
         start_q      <= start_d;
         line_q       <= line_d;
         issue_q      <= issue_d;
         resp_q       <= resp_d;
         cmd_rdy      <= cmd_rdy_d;
         busy         <= busy_d;
         line_val     <= line_val_d;
         mem_req_val  <= req_val_d;
         mem_req_type <= req_type_d;
         mem_req_addr <= req_addr_d;
         mem_req_data <= req_data_d;
      end
   end

endmodule

// File: doc/cache_line_burst_unit.md
Name: cache_line_burst_unit

Overview:
Line-transfer engine between the cache controller's refill/evict request path and the 4B word-wide memory port.
- Accepts one line command: read for refill, write for evict/flush.
- Splits it into WORDS_PER_LINE single-word memory requests and gathers in-order responses.
- For reads, presents the assembled line to the controller's refill datapath.
- Handles one command at a time.

Parameters:
WORDS_PER_LINE, 4, words per cache line; power of two, 2..16
DATA_W, 32, word width in bits
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_val  in  1  line command valid
cmd_rdy  out  1  line command ready; high only in IDLE
cmd_rw  in  1  1 = write line (evict), 0 = read line (refill)
cmd_addr  in  ADDR_W  byte address; any offset inside the line
cmd_wdata  in  WORDS_PER_LINE*DATA_W  line data for writes; word i at bits [i*DATA_W +: DATA_W]
mem_req_val  out  1  word request valid
mem_req_rdy  in  1  word request ready
mem_req_type  out  1  1 = write, 0 = read
mem_req_addr  out  ADDR_W  word byte address
mem_req_data  out  DATA_W  write data (0 for reads)
mem_resp_val  in  1  word response valid
mem_resp_rdy  out  1  word response ready
mem_resp_data  in  DATA_W  read data (ignored for write acks)
line_val  out  1  assembled read line valid
line_rdy  in  1  consumer accepts line
line_data  out  WORDS_PER_LINE*DATA_W  assembled line, same packing as cmd_wdata
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, XFER, DONE.
- IDLE:
  - cmd_rdy=1.
  - On cmd_val: latch rw, base = cmd_addr with low log2(WORDS_PER_LINE*4) bits cleared, start index, and wdata into a line buffer.
  - Clear issue_cnt and resp_cnt; go to XFER.
- XFER:
  - mem_req_val=1 while issue_cnt<WORDS_PER_LINE.
  - Request k uses word index w=(start+k) mod WORDS_PER_LINE; mem_req_addr = base + 4*w.
  - issue_cnt increments on mem_req_val&&mem_req_rdy.
  - mem_resp_rdy=1 while resp_cnt<issue_cnt. A response may be accepted in the same cycle its request is issued.
  - Response j belongs to word (start+j) mod WORDS_PER_LINE. For reads, mem_resp_data is written into that buffer slot; resp_cnt increments.
  - When resp_cnt reaches WORDS_PER_LINE: write commands go to IDLE, read commands go to DONE.
- DONE:
  - line_val=1 and line_data = buffer, both held stable until line_rdy.
  - On line_val&&line_rdy go to IDLE; cmd_rdy rises the following cycle.
- Counter width: log2(WORDS_PER_LINE)+1 bits; no wrap past WORDS_PER_LINE. Word index arithmetic wraps modulo WORDS_PER_LINE.
- A mem_resp_val arriving while mem_resp_rdy=0 is not consumed; the bench must not produce it.
- Latency: with an always-ready, zero-latency memory, a read completes in WORDS_PER_LINE+1 cycles from command accept to line_val.
- Reset, taking effect from any state including mid-transfer:
  - state=IDLE, counters=0; all val/rdy outputs 0 except cmd_rdy=1.
  - busy=0, mem_req_data=0, line_data=0.
  - Outstanding memory responses are abandoned.

Optional Feature:
Macro CACHE_BURST_CRIT_WORD_FIRST_EN.
- Defined: start = word-offset field of cmd_addr, i.e. bits [log2(WORDS_PER_LINE)+1:2]. The requested word is fetched first and the order wraps around the line.
- Undefined: start is always 0, giving ascending order from the line base.
- Write commands always use start=0 in both builds.

Test Plan:
- Read, cmd_addr=0x0000_1008, memory always ready and echoing the address as data.
  - Feature off: addresses 0x1000, 0x1004, 0x1008, 0x100C issued; line_data word i = 0x1000+4i; line_val on cycle 5.
- Same read with CACHE_BURST_CRIT_WORD_FIRST_EN: issue order 0x1008, 0x100C, 0x1000, 0x1004; line_data identical to the feature-off case.
- Write, cmd_addr=0x2000, wdata words 0xA0..0xA3: four write requests with matching data; 4 acks; back to IDLE with no line_val; cmd_rdy=1 next cycle.
- Backpressure: mem_req_rdy toggles 1,0,1,0, responses delayed 3 cycles, line_rdy held low 5 cycles → no lost or duplicated word; line_data stable while line_val=1 and line_rdy=0.
- Reset asserted after 2 of 4 read requests → next cycle busy=0, cmd_rdy=1, mem_req_val=0; a following read of 0x3000 completes correctly.
- Back-to-back: a write then a read issued with cmd_val held high → the second command is accepted only after the first returns to IDLE.
